uart_rx_ctrl: RTL and testbench

Receive-side frame sequencer for the UART RX path. It tracks start, data, parity and stop bit periods with internal edge and bit counters. It enables the data sampler, deserializer, start check, parity check and stop check at fixed points in each bit, and collects their verdicts into a single-cycle `data_valid` or error pulse. Frame configuration (`PAR_EN`, `PAR_TYP`, `Prescale`) is latched per frame and re-exported to the checkers.

---
 rtl/uart_rx_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART RX frame sequencer: walks start/data/parity/stop bit periods and times the checkers.
// Latency: START one cycle after RX_IN sampled low; verdict pulse at edge M+1 of the stop bit.
// Backpressure: none; the serial line cannot be stalled, so a verdict is a single-cycle pulse.
//
// Ports:
//   CLK, RST          oversampling clock, asynchronous active-low reset
//   RX_IN             serial line (idle high); only looked at in IDLE and at the end of STOP
//   PAR_EN, PAR_TYP   frame config, latched at start-bit detection
//   Prescale          oversampling ratio 8/16/32 (anything else runs as 8), latched per frame
//   sampled_bit       sampler output, consumed by the deserializer rather than by this block
//   strt_glitch, par_err, stp_err
//                     checker verdicts, read only while the matching enable is high
//   edge_cnt, bit_cnt oversample index within the bit, bit index within the frame (0 = start)
//   dat_samp_en       sampler enable (level, equals busy)
//   deser_en          deserializer shift strobe, once per data bit
//   strt_chk_en, parity_chk_en, stp_chk_en
//                     single-cycle checker enables at the bit check point M = P/2+2
//   par_typ_lat       latched parity type for the parity checker
//   data_valid, par_err_o, frm_err_o
//                     mutually exclusive single-cycle frame verdicts
//   busy              high in every state except IDLE
module uart_rx_ctrl (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  input  logic [5:0] Prescale,
  input  logic       sampled_bit,
  input  logic       strt_glitch,
  input  logic       par_err,
  input  logic       stp_err,
  output logic [5:0] edge_cnt,
  output logic [3:0] bit_cnt,
  output logic       dat_samp_en,
  output logic       deser_en,
  output logic       strt_chk_en,
  output logic       parity_chk_en,
  output logic       stp_chk_en,
  output logic       par_typ_lat,
  output logic       data_valid,
  output logic       par_err_o,
  output logic       frm_err_o,
  output logic       busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic [3:0] LAST_DATA_BIT = 4'd8;

  // Unsupported ratios fall back to 8 so the counters always have a sane wrap point.
  function automatic logic [5:0] eff_prescale(input logic [5:0] ps);
    case (ps)
      6'd16:   return 6'd16;
      6'd32:   return 6'd32;
      default: return 6'd8;
    endcase
  endfunction

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [5:0] p_lat;        // effective prescale of the frame in flight
  logic       par_en_lat;
  logic       par_sticky;   // parity verdict held from PARITY until the stop-bit decision

  logic [5:0] chk_pt;       // M = P/2 + 2
  logic       at_chk;
  logic       last_edge;
  logic       start_frame;

  // The deserializer consumes sampled_bit directly; it only passes this block's boundary.
  logic       unused_sampled_bit;
  assign unused_sampled_bit = sampled_bit;

  assign chk_pt    = {1'b0, p_lat[5:1]} + 6'd2;
  assign at_chk    = (edge_cnt == chk_pt);
  assign last_edge = (edge_cnt == (p_lat - 6'd1));

  // A new frame begins either from IDLE or straight out of the last stop-bit edge
  // when the next start bit is already on the line (back-to-back frames).
  assign start_frame = ((state == S_IDLE) && !RX_IN) ||
                       ((state == S_STOP) && last_edge && !RX_IN);

  // --------------------------------------------------------------------------
  // Next-state decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (!RX_IN) state_nxt = S_START;
      end
      S_START: begin
        // The start checker's verdict is only meaningful at the check point;
        // a glitch abandons the frame silently.
        if (at_chk && strt_glitch) state_nxt = S_IDLE;
        else if (last_edge)        state_nxt = S_DATA;
      end
      S_DATA: begin
        if (last_edge && (bit_cnt == LAST_DATA_BIT))
          state_nxt = par_en_lat ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (last_edge) state_nxt = S_STOP;
      end
      S_STOP: begin
        if (last_edge) state_nxt = RX_IN ? S_IDLE : S_START;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // --------------------------------------------------------------------------
  // Edge / bit counters. Both sit at zero whenever the sequencer is idle, and
  // restart from zero on every start-bit detection.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt <= 6'd0;
      bit_cnt  <= 4'd0;
    end else if ((state_nxt == S_IDLE) || start_frame) begin
      edge_cnt <= 6'd0;
      bit_cnt  <= 4'd0;
    end else if (last_edge) begin
      edge_cnt <= 6'd0;
      bit_cnt  <= bit_cnt + 4'd1;
    end else begin
      edge_cnt <= edge_cnt + 6'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Per-frame configuration. Sampled only at start-bit detection so that
  // changes on the config pins while a frame is in flight have no effect.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      p_lat       <= 6'd8;
      par_en_lat  <= 1'b0;
      par_typ_lat <= 1'b0;
    end else if (start_frame) begin
      p_lat       <= eff_prescale(Prescale);
      par_en_lat  <= PAR_EN;
      par_typ_lat <= PAR_TYP;
    end
  end

  // --------------------------------------------------------------------------
  // Parity verdict: captured at the parity check point, held until the stop
  // bit decides the frame, and cleared at the start of each frame.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_sticky <= 1'b0;
    end else if (start_frame) begin
      par_sticky <= 1'b0;
    end else if (parity_chk_en && par_err) begin
      par_sticky <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Frame verdict. Registered off the stop-check cycle, so it appears at edge
  // M+1. A framing error hides any parity error, and exactly one pulse fires
  // per completed frame. With P=8 this lands on the last stop edge, alongside
  // the STOP exit; the two are independent.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      data_valid <= 1'b0;
      par_err_o  <= 1'b0;
      frm_err_o  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err_o  <= 1'b0;
      frm_err_o  <= 1'b0;
      if (stp_chk_en) begin
        frm_err_o  <= stp_err;
        par_err_o  <= !stp_err && par_sticky;
        data_valid <= !stp_err && !par_sticky;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Enables: pure decodes of state and edge counter, hence single-cycle and
  // free of any combinational path from RX_IN.
  // --------------------------------------------------------------------------
  assign busy          = (state != S_IDLE);
  assign dat_samp_en   = busy;
  assign strt_chk_en   = (state == S_START)  && at_chk;
  assign deser_en      = (state == S_DATA)   && at_chk;
  assign parity_chk_en = (state == S_PARITY) && at_chk;
  assign stp_chk_en    = (state == S_STOP)   && at_chk;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_in = 1'b1;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic [5:0] prescale = 6'd8;
  logic       sampled_bit = 1'b1;
  logic       strt_glitch = 1'b0;
  logic       par_err = 1'b0;
  logic       stp_err = 1'b0;

  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       dat_samp_en, deser_en, strt_chk_en, parity_chk_en, stp_chk_en;
  logic       par_typ_lat, data_valid, par_err_o, frm_err_o, busy;

  uart_rx_ctrl dut (
    .CLK(clk), .RST(rst_n), .RX_IN(rx_in), .PAR_EN(par_en), .PAR_TYP(par_typ),
    .Prescale(prescale), .sampled_bit(sampled_bit), .strt_glitch(strt_glitch),
    .par_err(par_err), .stp_err(stp_err), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
    .dat_samp_en(dat_samp_en), .deser_en(deser_en), .strt_chk_en(strt_chk_en),
    .parity_chk_en(parity_chk_en), .stp_chk_en(stp_chk_en), .par_typ_lat(par_typ_lat),
    .data_valid(data_valid), .par_err_o(par_err_o), .frm_err_o(frm_err_o), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  localparam int K_VALID = 0;
  localparam int K_PAR   = 1;
  localparam int K_FRM   = 2;

  typedef struct {
    int         kind;
    int         cyc;
    logic [7:0] data;
    logic       typ;
    int         n_par;
  } exp_t;

  exp_t exp_q[$];

  // ---------------------------------------------------------------- monitor
  int         deser_n = 0;
  int         par_n   = 0;
  int         stp_n   = 0;
  logic [7:0] shreg   = 8'h00;

  always @(negedge clk) begin
    exp_t e;
    int   npulse;
    int   kind_got;
    if (!rst_n) begin
      deser_n = 0;
      par_n   = 0;
      stp_n   = 0;
    end else begin
      if (deser_en === 1'b1) begin
        shreg = {sampled_bit, shreg[7:1]};
        deser_n++;
      end
      if (parity_chk_en === 1'b1) par_n++;
      if (stp_chk_en === 1'b1)    stp_n++;
      npulse = int'(data_valid === 1'b1) + int'(par_err_o === 1'b1) + int'(frm_err_o === 1'b1);
      if (npulse != 0) begin
        chk("pulse_exclusive", npulse, 1);
        kind_got = (frm_err_o === 1'b1) ? K_FRM : (par_err_o === 1'b1) ? K_PAR : K_VALID;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, want no pulse", kind_got, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("verdict_kind", kind_got, e.kind);
          chk("verdict_cycle", cyc, e.cyc);
          chk("deser_data", shreg, e.data);
          chk("par_typ_lat", par_typ_lat, e.typ);
          chk("deser_count", deser_n, 8);
          chk("parity_chk_count", par_n, e.n_par);
          chk("stop_chk_count", stp_n, 1);
        end
        deser_n = 0;
        par_n   = 0;
        stp_n   = 0;
      end
    end
  end

  // ---------------------------------------------------------------- driver
  function automatic logic [19:0] all_outs();
    return {edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en, parity_chk_en,
            stp_chk_en, par_typ_lat, data_valid, par_err_o, frm_err_o, busy};
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      rx_in = 1'b1;
      sampled_bit = 1'b1;
    end
  endtask

  // Sends one frame on the line and plays the checkers' verdicts for it.
  // The expected outcome comes from the frame contents alone.
  task automatic drive_frame(input logic [7:0] data, input logic pe, input logic typ,
                             input logic [5:0] ps, input logic par_ok, input logic stop_bit,
                             input logic glitch, input logic do_rst);
    int          p;
    int          m;
    int          nbits;
    int          len;
    int          start;
    logic        par_bit;
    logic [10:0] bits;
    exp_t        e;
    p       = (ps == 6'd8 || ps == 6'd16 || ps == 6'd32) ? int'(ps) : 8;
    m       = p / 2 + 2;
    nbits   = pe ? 11 : 10;
    par_bit = (typ ? ~^data : ^data) ^ !par_ok;
    bits    = '1;
    bits[0] = 1'b0;
    bits[8:1] = data;
    if (pe) begin
      bits[9]  = par_bit;
      bits[10] = stop_bit;
    end else begin
      bits[9]  = stop_bit;
    end
    len = glitch ? p + 8 : nbits * p;
    for (int c = 0; c < len; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        start       = cyc;
        par_en      = pe;
        par_typ     = typ;
        prescale    = ps;
        strt_glitch = glitch;
        par_err     = pe ? !par_ok : 1'($urandom);
        stp_err     = !stop_bit;
        if (!glitch && !do_rst) begin
          e.kind  = !stop_bit ? K_FRM : (pe && !par_ok) ? K_PAR : K_VALID;
          e.cyc   = start + 1 + (9 + int'(pe)) * p + m + 1;
          e.data  = data;
          e.typ   = typ;
          e.n_par = int'(pe);
          exp_q.push_back(e);
        end
      end
      if (c == p + 2) begin
        // Config pins wander mid-frame; the frame in flight must ignore them.
        par_en   = 1'($urandom);
        par_typ  = ~par_typ;
        prescale = 6'($urandom_range(0, 63));
      end
      rx_in       = glitch ? (c >= 3) : bits[c / p];
      sampled_bit = rx_in;
      if (c == 1) begin
        @(negedge clk);
        chk("start_busy", busy, 1);
        chk("start_edge_cnt", edge_cnt, 0);
        chk("start_bit_cnt", bit_cnt, 0);
      end
      if (glitch && c == m + 1) begin
        @(negedge clk);
        chk("glitch_busy_at_chk", busy, 1);
        chk("glitch_strt_chk_en", strt_chk_en, 1);
      end
      if (glitch && c == m + 2) begin
        @(negedge clk);
        chk("glitch_idle", busy, 0);
      end
      if (do_rst && c == 1 + 4 * p + 3) begin
        @(negedge clk);
        chk("pre_rst_bit_cnt", bit_cnt, 4);
        chk("pre_rst_edge_cnt", edge_cnt, 3);
        rst_n = 1'b0;
        rx_in = 1'b1;
        sampled_bit = 1'b1;
        #1;
        chk("midframe_rst_outputs", all_outs(), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d verdicts outstanding", exp_q.size());
    $fatal(1);
  end

  initial begin
    int r;
    logic [5:0] ps;
    #2;
    chk("reset_outputs", all_outs(), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(4);
    chk("idle_after_reset", all_outs(), 0);

    // P=8, even parity, 0xA5 with correct parity bit 0 -> data_valid
    drive_frame(8'hA5, 1'b1, 1'b0, 6'd8, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(5);
    // same frame, parity bit 1 -> parity error
    drive_frame(8'hA5, 1'b1, 1'b0, 6'd8, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(5);
    // P=16, no parity, 0x3C with stop bit 0 -> framing error
    drive_frame(8'h3C, 1'b0, 1'b0, 6'd16, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(5);
    // start glitch at P=16
    drive_frame(8'h00, 1'b0, 1'b0, 6'd16, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("glitch_busy_after", busy, 0);
    // back-to-back at P=32, parity type differs per frame
    drive_frame(8'h96, 1'b1, 1'b0, 6'd32, 1'b1, 1'b1, 1'b0, 1'b0);
    drive_frame(8'h4E, 1'b1, 1'b1, 6'd32, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(5);
    // reset inside DATA at bit_cnt=4, then a clean frame
    drive_frame(8'hFF, 1'b1, 1'b1, 6'd16, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(3);
    drive_frame(8'h5A, 1'b1, 1'b1, 6'd16, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);

    // randomized frames, including unsupported prescale values
    for (int i = 0; i < 24; i++) begin
      r = $urandom_range(0, 7);
      ps = (r < 2) ? 6'd8 : (r < 4) ? 6'd16 : (r < 6) ? 6'd32 : (r == 6) ? 6'd12 : 6'd0;
      drive_frame(8'($urandom), 1'($urandom), 1'($urandom), ps,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7) == 0, 1'b0);
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 6));
    end

    idle(4);
    for (int w = 0; w < 2000 && exp_q.size() != 0; w++) @(posedge clk);
    chk("verdicts_outstanding", exp_q.size(), 0);
    chk("final_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
